// File: rtl/score_text_gen_pkg.sv
// score_text_pkg: char codes, overlay strings, FSM states and helpers for score_text_gen.
package score_text_pkg;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_DASH  = 7'h2D;
  localparam logic [6:0] CH_QMARK = 7'h3F;
  localparam logic [6:0] CH_ARROW = 7'h18;
  localparam logic [47:0] STR_SCORE  = "SCORE:";
  localparam logic [47:0] STR_PLAYER = "Player";
  localparam logic [31:0] STR_WIN    = "-win";
  localparam int SCORE_SAT = 99;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;
  // character i of an n-character string packed first-char-in-MSB
  function automatic logic [7:0] str_ch(input logic [47:0] s, input int n, input int i);
    return s[(n-1-i)*8 +: 8];
  endfunction
endpackage

// File: rtl/score_text_gen_if.sv
// score_text_gen_if: score request and text-lookup signals of score_text_gen.
interface score_text_gen_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W = 7,
  parameter int COLS = 16,
  parameter int ROWS = 16
);
  logic [NUM_PLAYERS*SCORE_W-1:0] score_bin;
  logic score_valid;
  logic game_over;
  logic [$clog2(NUM_PLAYERS)-1:0] winner_idx;
  logic [$clog2(ROWS)+$clog2(COLS)-1:0] char_xy;
  logic [6:0] char_code_out;
  logic busy;
  modport master(output score_bin, score_valid, game_over, winner_idx, char_xy, input char_code_out, busy);
  modport slave(input score_bin, score_valid, game_over, winner_idx, char_xy, output char_code_out, busy);
endinterface

// File: rtl/score_text_gen_bin2bcd_seq.sv
// bin2bcd_seq: shift/add-3 binary-to-BCD datapath, one bit per step, two BCD digits out.
module bin2bcd_seq #(parameter int W = 7) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic [W-1:0] bin,
  output logic [7:0] bcd
);
  logic [W-1:0] sr;
  logic [7:0] adj;
  always_comb adj = {bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4],
                     bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) {bcd, sr} <= '0;
    else if (load) {bcd, sr} <= {8'h00, bin};
    else if (step) {bcd, sr} <= {adj, sr} << 1;
endmodule

// File: rtl/score_text_gen.sv
// score_text_gen: score-to-decimal converter with double-buffered digits and text-grid char lookup.
// Optional SCORE_TEXT_LEADING_ZERO_BLANK_EN shows a leading tens '0' as a space.
module score_text_gen import score_text_pkg::*; #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W = 7,
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int BLINK_DIV = 25_000_000
) (
  input logic clk,
  input logic rst,
  score_text_gen_if.slave bus
);
  localparam int IW = $clog2(NUM_PLAYERS);
  localparam int SW = $clog2(SCORE_W);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  state_t state, nxt;
  logic [SW-1:0] sc;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic pending, phase, load, step, last;
  logic [SCORE_W-1:0] sq [NUM_PLAYERS];
  logic [SCORE_W-1:0] bin;
  logic [7:0] bcd;
  logic [6:0] stg_t [NUM_PLAYERS];
  logic [6:0] stg_u [NUM_PLAYERS];
  logic [6:0] dsp_t [NUM_PLAYERS];
  logic [6:0] dsp_u [NUM_PLAYERS];
  logic [6:0] code, code_q, tens, units, wch;
  int ri, ci;
  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    return int'(s) > SCORE_SAT ? SCORE_W'(SCORE_SAT) : s;
  endfunction
  assign last = idx == IW'(NUM_PLAYERS-1);
  assign bin = state == LOAD ? sat(bus.score_bin[0 +: SCORE_W]) : sat(sq[idx + 1'b1]);
  assign bus.busy = state != IDLE;
  assign bus.char_code_out = code_q;
  bin2bcd_seq #(.W(SCORE_W)) u_bcd (.clk(clk), .rst(rst), .load(load), .step(step), .bin(bin), .bcd(bcd));
  always_comb begin
    nxt = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: nxt = bus.score_valid ? LOAD : IDLE;
      LOAD: begin load = 1'b1; nxt = SHIFT; end
      SHIFT: begin step = 1'b1; nxt = sc == SW'(SCORE_W-1) ? STORE : SHIFT; end
      STORE: begin load = !last; nxt = last ? COMMIT : SHIFT; end
      COMMIT: nxt = (pending || bus.score_valid) ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sc <= '0;
      idx <= '0;
      pending <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        sq[p] <= '0;
        stg_t[p] <= CH_ZERO;
        stg_u[p] <= CH_ZERO;
        dsp_t[p] <= CH_ZERO;
        dsp_u[p] <= CH_ZERO;
      end
    end else begin
      state <= nxt;
      sc <= state == SHIFT ? sc + 1'b1 : '0;
      pending <= state == COMMIT ? 1'b0 : (state != IDLE && bus.score_valid) ? 1'b1 : pending;
      if (state == LOAD) begin
        idx <= '0;
        for (int p = 0; p < NUM_PLAYERS; p++) sq[p] <= bus.score_bin[p*SCORE_W +: SCORE_W];
      end
      if (state == STORE) begin
        stg_t[idx] <= CH_ZERO + {3'b000, bcd[7:4]};
        stg_u[idx] <= CH_ZERO + {3'b000, bcd[3:0]};
        if (!last) idx <= idx + 1'b1;
      end
      if (state == COMMIT) begin
        dsp_t <= stg_t;
        dsp_u <= stg_u;
      end
    end
  // phase is held visible while the game runs so the winner line appears at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcnt <= '0;
      phase <= 1'b1;
    end else if (!bus.game_over) begin
      bcnt <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV-1)) begin
      bcnt <= '0;
      phase <= !phase;
    end else bcnt <= bcnt + 1'b1;
  assign ri = int'(bus.char_xy[RW+CW-1:CW]);
  assign ci = int'(bus.char_xy[CW-1:0]);
  assign wch = int'(bus.winner_idx) < NUM_PLAYERS ? 7'(int'(CH_ZERO) + 1 + int'(bus.winner_idx)) : CH_QMARK;
  always_comb begin
    tens = CH_ZERO;
    units = CH_ZERO;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (ri == p + 1) begin
        tens = dsp_t[p];
        units = dsp_u[p];
      end
`ifdef SCORE_TEXT_LEADING_ZERO_BLANK_EN
    tens = tens == CH_ZERO ? CH_SPACE : tens;
`endif
    code = CH_SPACE;
    if (ri == ROWS-1) code = CH_ARROW;
    else if (ri == 0) code = ci < 6 ? 7'(str_ch(STR_SCORE, 6, ci)) : CH_SPACE;
    else if (ri <= NUM_PLAYERS)
      code = ci < 6 ? 7'(str_ch(STR_PLAYER, 6, ci)) : ci == 6 ? 7'(int'(CH_ZERO) + ri) :
             ci == 7 ? CH_COLON : ci == 8 ? tens : ci == 9 ? units : CH_SPACE;
    else if (ri == NUM_PLAYERS+1 && bus.game_over && phase)
      code = ci < 6 ? 7'(str_ch(STR_PLAYER, 6, ci)) : ci == 6 ? CH_COLON : ci == 7 ? wch :
             ci == 8 ? CH_DASH : ci < 12 ? 7'(str_ch({16'h0000, STR_WIN}, 4, ci - 8)) : CH_SPACE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) code_q <= CH_SPACE;
    else code_q <= code;
endmodule
